// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch stage and the rest of the core.
package rv32_pkg;

    localparam logic [31:0] RV32_NOP         = 32'h0000_0013;
    localparam logic [31:0] RV32_DEFAULT_PC  = 32'h0000_0000;

    typedef enum logic {
        FS_RUN,
        FS_FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect input, IF/ID handshake and fault report.
interface fetch_stage_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  id_ready;
    logic                  id_valid;
    logic [31:0]           id_instr;
    logic [31:0]           id_pc;
    logic                  fetch_fault;
    logic [31:0]           fault_pc;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, fetch_fault, fault_pc,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, fetch_fault, fault_pc,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32IM instruction fetch: PC, IF/ID register with valid/ready handshake,
// redirect handling and a sticky fault on misaligned redirect targets.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = RV32_DEFAULT_PC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic         fetch_fault_q, fetch_fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        fetch_fault_d = fetch_fault_q;
        fault_pc_d    = fault_pc_q;

        case (state_q)
            FS_RUN: begin
                // Redirect beats the handshake: a held instruction is squashed, never transferred.
                if (bus.redirect_valid) begin
                    id_valid_d = 1'b0;
                    id_instr_d = RV32_NOP;
                    if (bus.redirect_pc[1:0] == 2'b00) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        state_d       = FS_FAULT;
                        fetch_fault_d = 1'b1;
                        fault_pc_d    = bus.redirect_pc;
                    end
                end else if (!id_valid_q || bus.id_ready) begin
                    id_valid_d = 1'b1;
                    id_instr_d = bus.imem_data;
                    id_pc_d    = pc_q;
                    pc_d       = pc_q + 32'd4;
                end
            end
            FS_FAULT: begin
                id_valid_d = 1'b0;
            end
            default: begin
                state_d = FS_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= RV32_NOP;
            id_pc_q       <= '0;
            fetch_fault_q <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            fetch_fault_q <= fetch_fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign bus.imem_addr   = pc_q[ADDR_WIDTH+1:2];
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-output queue for delivered instructions.
module tb_fetch_stage;

    localparam int unsigned AW = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    fetch_stage_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_stage #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory image: word k holds 32'h1000_0000 + k.
    assign bus.imem_data = 32'h1000_0000 + {24'h0, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        logic [7:0] w;
        w = pc[9:2];
        e.pc = pc;
        e.instr = 32'h1000_0000 + {24'h0, w};
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid"}, {31'h0, bus.id_valid}, 32'h1);
            check({tag, ".pc"}, bus.id_pc, e.pc);
            check({tag, ".instr"}, bus.id_instr, e.instr);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".valid"}, {31'h0, bus.id_valid}, 32'h0);
        check({tag, ".instr"}, bus.id_instr, NOP);
        check({tag, ".pc"}, bus.id_pc, 32'h0);
        check({tag, ".fault"}, {31'h0, bus.fetch_fault}, 32'h0);
        check({tag, ".fault_pc"}, bus.fault_pc, 32'h0);
        check({tag, ".addr"}, {24'h0, bus.imem_addr}, 32'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;

        #12;
        check_reset("reset");
        rst = 1'b0;

        // Stream from reset
        for (int k = 0; k < 3; k++) begin
            push(32'(k * 4));
            step();
            check_out($sformatf("stream%0d", k));
        end

        // Stall with id_pc = 8
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d.valid", k), {31'h0, bus.id_valid}, 32'h1);
            check($sformatf("stall%0d.pc", k), bus.id_pc, 32'h8);
            check($sformatf("stall%0d.instr", k), bus.id_instr, 32'h1000_0002);
            check($sformatf("stall%0d.addr", k), {24'h0, bus.imem_addr}, 32'd3);
        end
        bus.id_ready = 1'b1;
        push(32'hC);
        step();
        check_out("resume12");
        push(32'h10);
        step();
        check_out("resume16");

        // Aligned redirect while stalled at id_pc = 16
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        check("redir.bubble_valid", {31'h0, bus.id_valid}, 32'h0);
        check("redir.bubble_instr", bus.id_instr, NOP);
        push(32'h40);
        step();
        check_out("redir40");
        push(32'h44);
        step();
        check_out("redir44");

        // PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap.bubble_valid", {31'h0, bus.id_valid}, 32'h0);
        check("wrap.addr255", {24'h0, bus.imem_addr}, 32'd255);
        push(32'hFFFF_FFFC);
        step();
        check_out("wrap_top");
        check("wrap.addr0", {24'h0, bus.imem_addr}, 32'd0);
        push(32'h0);
        step();
        check_out("wrap_zero");

        // Misaligned redirect; pc is 4 here
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h22;
        step();
        check("fault.flag", {31'h0, bus.fetch_fault}, 32'h1);
        check("fault.pc", bus.fault_pc, 32'h22);
        check("fault.valid", {31'h0, bus.id_valid}, 32'h0);
        check("fault.addr", {24'h0, bus.imem_addr}, 32'd1);
        bus.redirect_pc = 32'h80;
        step();
        bus.redirect_valid = 1'b0;
        check("fault.ignore_flag", {31'h0, bus.fetch_fault}, 32'h1);
        check("fault.ignore_pc", bus.fault_pc, 32'h22);
        check("fault.ignore_addr", {24'h0, bus.imem_addr}, 32'd1);
        step();
        check("fault.hold_valid", {31'h0, bus.id_valid}, 32'h0);

        // Reset between edges clears the fault
        #2 rst = 1'b1;
        #1 check_reset("fault_rst");
        #1 rst = 1'b0;
        push(32'h0);
        step();
        check_out("post_fault0");
        push(32'h4);
        step();
        check_out("post_fault4");

        // Async reset mid-stream
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        #1 rst = 1'b0;
        push(32'h0);
        step();
        check_out("post_rst0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32IM core. Holds the program counter, drives the word address of the combinational instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. It presents the result to decode with a valid/ready handshake, and accepts control-flow redirects from execute. A misaligned redirect target halts fetch and raises a fault.

## Interface
- `ADDR_WIDTH`, 8: instruction memory word-address width (2^ADDR_WIDTH words).
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH  word address to instruction memory, equal to `pc[ADDR_WIDTH+1:2]`.
- `imem_data`  in  32  instruction returned combinationally by instruction memory.
- `redirect_valid`  in  1  execute requests a PC change (taken branch, JAL, JALR).
- `redirect_pc`  in  32  redirect target byte address.
- `id_ready`  in  1  decode accepts IF/ID contents this cycle.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_instr`  out  32  fetched instruction.
- `id_pc`  out  32  byte address of `id_instr`.
- `fetch_fault`  out  1  misaligned redirect seen; fetch halted.
- `fault_pc`  out  32  offending redirect target.

## Operation
- State register `state`: `FS_RUN` or `FS_FAULT`.
- **Advance** (`FS_RUN`, no redirect, `!id_valid || id_ready`):
  - `id_instr <= imem_data`, `id_pc <= pc`, `id_valid <= 1`.
  - `pc <= pc + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **Stall** (`FS_RUN`, no redirect, `id_valid && !id_ready`): PC and IF/ID hold unchanged.
- **Redirect** (`redirect_valid` in `FS_RUN`): highest priority, regardless of `id_ready`.
  - `id_valid <= 0`; `id_instr` is set to NOP 32'h0000_0013. The squashed instruction is dropped.
  - If `redirect_pc[1:0] == 0`: `pc <= redirect_pc`.
  - Otherwise: `state <= FS_FAULT`, `fault_pc <= redirect_pc`, `fetch_fault <= 1`, and PC holds.
- **FS_FAULT**: absorbing state. `id_valid` stays 0, PC frozen, redirects ignored. Exit only via `rst`.
- Addresses beyond instruction memory depth alias through `imem_addr` truncation. Memory returns NOP for unpopulated words; no bounds check in this block.

## Timing
- Reset values, applied immediately on `rst` high: `pc = RESET_PC`, `state = FS_RUN`, `id_valid = 0`, `id_instr = 32'h0000_0013`, `id_pc = 0`, `fetch_fault = 0`, `fault_pc = 0`.
- `imem_addr` is combinational from `pc`; memory read completes in the same cycle.
- Fetch-to-decode latency is 1 cycle. The instruction at `pc` in cycle N appears on `id_*` in cycle N+1.
- Throughput: 1 instruction per cycle while `id_ready` is held high.
- First valid instruction: the first rising edge after `rst` deasserts loads `RESET_PC`'s instruction.
- Redirect at edge N: `id_valid = 0` in cycle N+1; the target instruction is valid in cycle N+2. This is a 1-bubble penalty.
- Handshake: the transfer completes on an edge where `id_valid && id_ready`. While stalled, `id_*` must remain stable.
- Redirect while stalled: the held instruction is flushed, and no transfer occurs on that edge.
- `rst` asserted mid-stall or in `FS_FAULT`: all state returns to reset values asynchronously.

## Structure
- Shared package `rv32_pkg` holds:
  - `RV32_NOP = 32'h0000_0013`.
  - Default `RESET_PC`.
  - `typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t`.
- Single module; no sub-module. The PC, IF/ID register and state register are small enough to keep flat.
- Instruction memory is instantiated by the core top level, not inside this block.

## Test plan
- **Reset and stream:** reset, `id_ready = 1`, memory word k = 32'h1000_0000 + k. Required: `id_pc` = 0, 4, 8…; `id_instr` = 32'h1000_0000, 32'h1000_0001…; `id_valid` = 1 from the first edge after reset.
- **Stall:** drop `id_ready` for 3 cycles while `id_pc` = 8. Required: `id_pc`/`id_instr` hold for 3 cycles; `imem_addr` holds at 3; the stream resumes at `id_pc` = 12 with no skip or duplicate.
- **Aligned redirect:** pulse `redirect_valid` with `redirect_pc` = 32'h40 while stalled at `id_pc` = 16. Required: one cycle `id_valid = 0` with `id_instr` = NOP, then `id_pc` = 32'h40, then 32'h44.
- **Misaligned redirect:** `redirect_pc` = 32'h22. Required: `fetch_fault = 1` and `fault_pc` = 32'h22 next cycle; `id_valid` stays 0 and later redirects are ignored; `rst` clears the fault.
- **PC wrap:** redirect to 32'hFFFF_FFFC. Required: `id_pc` = 32'hFFFF_FFFC, then `id_pc` = 0; `imem_addr` sequence 255, 0.
- **Async reset mid-stream:** assert `rst` between clock edges. Required: outputs reach reset values before the next edge.
